// File: rtl/pkt_rx_checker_if.sv
// Receive-side test-packet stream: 134-bit beats plus a packet-end verdict.
// Strobe protocol, no backpressure: the checker consumes a beat on every cycle in_rxc_data_wr is
// high, and in_rxc_data_valid is sampled only while in_rxc_data_valid_wr is high.
interface pkt_rx_checker_if;
    logic [133:0] in_rxc_data;
    logic         in_rxc_data_wr;
    logic         in_rxc_data_valid;
    logic         in_rxc_data_valid_wr;

    modport master (
        output in_rxc_data,
        output in_rxc_data_wr,
        output in_rxc_data_valid,
        output in_rxc_data_valid_wr
    );

    modport slave (
        input in_rxc_data,
        input in_rxc_data_wr,
        input in_rxc_data_valid,
        input in_rxc_data_valid_wr
    );
endinterface

// File: rtl/pkt_rx_checker.sv
// Parses returned test packets (metadata, header, sent timestamp, seq/slot beat), checks length
// and per-flow sequence continuity, measures one-way latency, and keeps the statistics counters.
module pkt_rx_checker #(
    parameter int    FLOW_ID_LSB = 0,
    parameter string PLATFORM    = "xilinx"
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cnt_rst,
    input  logic [47:0]     timestamp,
    pkt_rx_checker_if.slave rxc,
    output logic [31:0]     out_rxc_flow_cnt_0,
    output logic [31:0]     out_rxc_flow_cnt_1,
    output logic [31:0]     out_rxc_flow_cnt_2,
    output logic [31:0]     out_rxc_flow_cnt_3,
    output logic [31:0]     out_rxc_flow_cnt_4,
    output logic [31:0]     out_rxc_flow_cnt_5,
    output logic [31:0]     out_rxc_flow_cnt_6,
    output logic [31:0]     out_rxc_flow_cnt_7,
    output logic [31:0]     out_rxc_lost_cnt,
    output logic [31:0]     out_rxc_seq_err_cnt,
    output logic [31:0]     out_rxc_len_err_cnt,
    output logic [47:0]     out_rxc_last_latency,
    output logic [47:0]     out_rxc_max_latency,
    output logic [8:0]      out_rxc_slot_id,
    output logic [3:0]      out_rxc_slot_shift,
    output logic [2:0]      dbg_state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MD2   = 3'd1;
    localparam logic [2:0] HDR   = 3'd2;
    localparam logic [2:0] TS    = 3'd3;
    localparam logic [2:0] SEQ   = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;

    // The vendor tag has no functional effect on this block.
    if (PLATFORM == "") begin : g_untagged_platform
    end

    logic [2:0]  state;
    logic [1:0]  hdr_cnt;
    logic [11:0] pkt_len;
    logic [11:0] data_bytes;
    logic [2:0]  flow_q;
    logic [47:0] sent_ts_q;
    logic [31:0] seq_q;
    logic [8:0]  slot_id_q;
    logic [3:0]  slot_shift_q;

    logic [31:0] flow_cnt [8];
    logic [31:0] expected_seq [8];
    logic [31:0] lost_cnt, seq_err_cnt, len_err_cnt;
    logic [47:0] last_latency, max_latency;
    logic [8:0]  slot_id_r;
    logic [3:0]  slot_shift_r;

    logic [1:0]   beat_type;
    logic [3:0]   beat_inval;
    logic [127:0] beat_data;
    logic         unused_payload;

    assign beat_type      = rxc.in_rxc_data[133:132];
    assign beat_inval     = rxc.in_rxc_data[131:128];
    assign beat_data      = rxc.in_rxc_data[127:0];
    assign unused_payload = ^beat_data;

    logic is_head, is_tail, beat_wr;
    assign beat_wr = rxc.in_rxc_data_wr;
    assign is_head = (beat_type == 2'b01);
    assign is_tail = (beat_type == 2'b10);

    // A tail before the timestamp beat can never satisfy the length check.
    logic        reached_ts, seq_present;
    logic [11:0] bytes_total;
    logic        len_ok, commit_evt, good_pkt, abort_pkt, len_err_inc;

    assign reached_ts  = (state == TS) || (state == SEQ) || (state == DRAIN);
    assign seq_present = (state == SEQ) || (state == DRAIN);
    assign bytes_total = data_bytes + 12'd16 - (is_tail ? {8'd0, beat_inval} : 12'd0);
    assign len_ok      = reached_ts && (bytes_total == (pkt_len - 12'd32));
    assign commit_evt  = beat_wr && is_tail && (state != IDLE)
                         && rxc.in_rxc_data_valid_wr && rxc.in_rxc_data_valid;
    assign good_pkt    = commit_evt && len_ok;
    assign abort_pkt   = beat_wr && is_head && (state != IDLE);
    assign len_err_inc = abort_pkt || (commit_evt && !len_ok);

    // When the tail is the TS or SEQ beat itself, its fields are taken straight off the bus.
    logic [47:0] cur_sent_ts;
    logic [31:0] cur_seq;
    logic [8:0]  cur_slot_id;
    logic [3:0]  cur_slot_shift;
    logic [47:0] latency;

    assign cur_sent_ts    = (state == TS)  ? beat_data[47:0]   : sent_ts_q;
    assign cur_seq        = (state == SEQ) ? beat_data[127:96] : seq_q;
    assign cur_slot_id    = (state == SEQ) ? beat_data[8:0]    : slot_id_q;
    assign cur_slot_shift = (state == SEQ) ? beat_data[19:16]  : slot_shift_q;
    assign latency        = timestamp - cur_sent_ts;

    logic [31:0] exp_cur, gap_amt, lost_next;
    logic [32:0] exp_next, lost_sum;
    logic        seq_in_order, seq_gap;

    assign exp_cur      = expected_seq[flow_q];
    assign exp_next     = {1'b0, exp_cur} + 33'd1;
    assign seq_in_order = ({1'b0, cur_seq} == exp_next);
    assign seq_gap      = ({1'b0, cur_seq} > exp_next);
    assign gap_amt      = cur_seq - exp_cur - 32'd1;
    assign lost_sum     = {1'b0, lost_cnt} + {1'b0, gap_amt};
    assign lost_next    = lost_sum[32] ? 32'hFFFF_FFFF : lost_sum[31:0];

    // Parser: a head beat always restarts parsing, whatever state it interrupts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hdr_cnt      <= 2'd0;
            pkt_len      <= 12'd0;
            data_bytes   <= 12'd0;
            flow_q       <= 3'd0;
            sent_ts_q    <= 48'd0;
            seq_q        <= 32'd0;
            slot_id_q    <= 9'd0;
            slot_shift_q <= 4'd0;
        end else if (beat_wr) begin
            if (is_head) begin
                pkt_len    <= beat_data[107:96];
                data_bytes <= 12'd0;
                state      <= MD2;
            end else begin
                case (state)
                    MD2: begin
                        hdr_cnt <= 2'd0;
                        state   <= is_tail ? IDLE : HDR;
                    end
                    HDR: begin
                        data_bytes <= data_bytes + 12'd16;
                        if (hdr_cnt == 2'd0) flow_q <= beat_data[FLOW_ID_LSB +: 3];
                        if (is_tail)              state <= IDLE;
                        else if (hdr_cnt == 2'd2) state <= TS;
                        else                      hdr_cnt <= hdr_cnt + 2'd1;
                    end
                    TS: begin
                        data_bytes <= data_bytes + 12'd16;
                        sent_ts_q  <= beat_data[47:0];
                        state      <= is_tail ? IDLE : SEQ;
                    end
                    SEQ: begin
                        data_bytes   <= data_bytes + 12'd16;
                        seq_q        <= beat_data[127:96];
                        slot_id_q    <= beat_data[8:0];
                        slot_shift_q <= beat_data[19:16];
                        state        <= is_tail ? IDLE : DRAIN;
                    end
                    DRAIN: begin
                        data_bytes <= data_bytes + 12'd16;
                        if (is_tail) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Statistics: cnt_rst wins over a commit landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                flow_cnt[i]     <= 32'd0;
                expected_seq[i] <= 32'd0;
            end
            lost_cnt     <= 32'd0;
            seq_err_cnt  <= 32'd0;
            len_err_cnt  <= 32'd0;
            last_latency <= 48'd0;
            max_latency  <= 48'd0;
            slot_id_r    <= 9'd0;
            slot_shift_r <= 4'd0;
        end else if (cnt_rst) begin
            for (int i = 0; i < 8; i++) begin
                flow_cnt[i]     <= 32'd0;
                expected_seq[i] <= 32'd0;
            end
            lost_cnt     <= 32'd0;
            seq_err_cnt  <= 32'd0;
            len_err_cnt  <= 32'd0;
            last_latency <= 48'd0;
            max_latency  <= 48'd0;
            slot_id_r    <= 9'd0;
            slot_shift_r <= 4'd0;
        end else begin
            if (len_err_inc) len_err_cnt <= len_err_cnt + 32'd1;
            if (good_pkt) begin
                flow_cnt[flow_q] <= flow_cnt[flow_q] + 32'd1;
                last_latency     <= latency;
                if (latency > max_latency) max_latency <= latency;
                if (seq_present) begin
                    expected_seq[flow_q] <= cur_seq;
                    slot_id_r            <= cur_slot_id;
                    slot_shift_r         <= cur_slot_shift;
                    if (!seq_in_order) seq_err_cnt <= seq_err_cnt + 32'd1;
                    if (seq_gap)       lost_cnt    <= lost_next;
                end
            end
        end
    end

    assign out_rxc_flow_cnt_0   = flow_cnt[0];
    assign out_rxc_flow_cnt_1   = flow_cnt[1];
    assign out_rxc_flow_cnt_2   = flow_cnt[2];
    assign out_rxc_flow_cnt_3   = flow_cnt[3];
    assign out_rxc_flow_cnt_4   = flow_cnt[4];
    assign out_rxc_flow_cnt_5   = flow_cnt[5];
    assign out_rxc_flow_cnt_6   = flow_cnt[6];
    assign out_rxc_flow_cnt_7   = flow_cnt[7];
    assign out_rxc_lost_cnt     = lost_cnt;
    assign out_rxc_seq_err_cnt  = seq_err_cnt;
    assign out_rxc_len_err_cnt  = len_err_cnt;
    assign out_rxc_last_latency = last_latency;
    assign out_rxc_max_latency  = max_latency;
    assign out_rxc_slot_id      = slot_id_r;
    assign out_rxc_slot_shift   = slot_shift_r;
    assign dbg_state            = state;

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Bench for pkt_rx_checker: a packet-level reference model pushes expected counter snapshots
// into a queue as each packet is driven; the snapshot is popped and compared after the commit.
module tb_pkt_rx_checker;
    localparam int FLOW_LSB = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnt_rst;
    logic [47:0] timestamp;
    always #5 clk = ~clk;

    logic [31:0] flow_cnt_o [8];
    logic [31:0] lost_o, seq_err_o, len_err_o;
    logic [47:0] last_lat_o, max_lat_o;
    logic [8:0]  slot_id_o;
    logic [3:0]  slot_shift_o;
    logic [2:0]  dbg_state_o;

    pkt_rx_checker_if rxc_if ();

    pkt_rx_checker #(.FLOW_ID_LSB(FLOW_LSB), .PLATFORM("xilinx")) dut (
        .clk(clk), .rst_n(rst_n), .cnt_rst(cnt_rst), .timestamp(timestamp), .rxc(rxc_if),
        .out_rxc_flow_cnt_0(flow_cnt_o[0]), .out_rxc_flow_cnt_1(flow_cnt_o[1]),
        .out_rxc_flow_cnt_2(flow_cnt_o[2]), .out_rxc_flow_cnt_3(flow_cnt_o[3]),
        .out_rxc_flow_cnt_4(flow_cnt_o[4]), .out_rxc_flow_cnt_5(flow_cnt_o[5]),
        .out_rxc_flow_cnt_6(flow_cnt_o[6]), .out_rxc_flow_cnt_7(flow_cnt_o[7]),
        .out_rxc_lost_cnt(lost_o), .out_rxc_seq_err_cnt(seq_err_o), .out_rxc_len_err_cnt(len_err_o),
        .out_rxc_last_latency(last_lat_o), .out_rxc_max_latency(max_lat_o),
        .out_rxc_slot_id(slot_id_o), .out_rxc_slot_shift(slot_shift_o), .dbg_state(dbg_state_o)
    );

    // ---------------- reference model and scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    logic [47:0] exp_q [$];

    logic [31:0] m_flow_cnt [8];
    logic [31:0] m_exp_seq [8];
    logic [31:0] m_lost, m_seq_err, m_len_err;
    logic [47:0] m_last_lat, m_max_lat;
    logic [8:0]  m_slot_id;
    logic [3:0]  m_slot_shift;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_flow_cnt[i] = '0;
            m_exp_seq[i]  = '0;
        end
        m_lost = '0; m_seq_err = '0; m_len_err = '0;
        m_last_lat = '0; m_max_lat = '0; m_slot_id = '0; m_slot_shift = '0;
    endtask

    task automatic model_pkt(input int f, input logic [11:0] pkt_len, input int n_data,
                             input logic [3:0] inv, input bit valid, input logic [31:0] seq,
                             input logic [47:0] sent, input logic [47:0] ts,
                             input logic [8:0] sid, input logic [3:0] sh, input bit crst);
        logic [11:0] bytes, want;
        logic [47:0] lat;
        longint      s, e, tot;
        if (crst) begin
            model_clear();
            return;
        end
        if (!valid) return;
        if (n_data < 4) begin
            m_len_err++;
            return;
        end
        bytes = 12'(n_data * 16) - {8'd0, inv};
        want  = pkt_len - 12'd32;
        if (bytes != want) begin
            m_len_err++;
            return;
        end
        m_flow_cnt[f]++;
        lat = ts - sent;
        m_last_lat = lat;
        if (lat > m_max_lat) m_max_lat = lat;
        if (n_data >= 5) begin
            s = longint'(seq);
            e = longint'(m_exp_seq[f]);
            if (s > e + 1) begin
                m_seq_err++;
                tot = longint'(m_lost) + (s - e - 1);
                m_lost = (tot > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : tot[31:0];
            end else if (s != e + 1) begin
                m_seq_err++;
            end
            m_exp_seq[f] = seq;
            m_slot_id    = sid;
            m_slot_shift = sh;
        end
    endtask

    task automatic push_expected(input int f);
        exp_q.push_back({16'd0, m_flow_cnt[f]});
        exp_q.push_back({16'd0, m_lost});
        exp_q.push_back({16'd0, m_seq_err});
        exp_q.push_back({16'd0, m_len_err});
        exp_q.push_back(m_last_lat);
        exp_q.push_back(m_max_lat);
        exp_q.push_back({39'd0, m_slot_id});
        exp_q.push_back({44'd0, m_slot_shift});
    endtask

    function automatic logic [47:0] observed(input int k, input int f);
        case (k)
            0:       return {16'd0, flow_cnt_o[f]};
            1:       return {16'd0, lost_o};
            2:       return {16'd0, seq_err_o};
            3:       return {16'd0, len_err_o};
            4:       return last_lat_o;
            5:       return max_lat_o;
            6:       return {39'd0, slot_id_o};
            default: return {44'd0, slot_shift_o};
        endcase
    endfunction

    function automatic string field_name(input int k);
        case (k)
            0: return "flow_cnt"; 1: return "lost_cnt"; 2: return "seq_err_cnt";
            3: return "len_err_cnt"; 4: return "last_latency"; 5: return "max_latency";
            6: return "slot_id"; default: return "slot_shift";
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_beat(input logic [1:0] typ, input logic [3:0] inv, input logic [127:0] d,
                              input logic vwr, input logic vld, input logic [47:0] ts,
                              input logic crst);
        rxc_if.in_rxc_data          = {typ, inv, d};
        rxc_if.in_rxc_data_wr       = 1'b1;
        rxc_if.in_rxc_data_valid_wr = vwr;
        rxc_if.in_rxc_data_valid    = vld;
        timestamp                   = ts;
        cnt_rst                     = crst;
        @(posedge clk);
        #1;
        rxc_if.in_rxc_data_wr       = 1'b0;
        rxc_if.in_rxc_data_valid_wr = 1'b0;
        rxc_if.in_rxc_data_valid    = 1'b0;
        cnt_rst                     = 1'b0;
    endtask

    task automatic send_pkt(input int f, input logic [11:0] pkt_len, input int n_data,
                            input logic [3:0] inv, input bit valid, input logic [31:0] seq,
                            input logic [47:0] sent, input logic [47:0] ts_tail,
                            input logic [8:0] sid, input logic [3:0] sh, input bit crst);
        int           total;
        logic [127:0] d;
        logic [1:0]   typ;
        bit           last;
        model_pkt(f, pkt_len, n_data, inv, valid, seq, sent, ts_tail, sid, sh, crst);
        push_expected(f);
        total = 2 + n_data;
        for (int i = 0; i < total; i++) begin
            d    = {$urandom, $urandom, $urandom, $urandom};
            last = (i == total - 1);
            typ  = (i == 0) ? 2'b01 : (last ? 2'b10 : 2'b11);
            if (i == 0) d[107:96] = pkt_len;
            if (i == 2) d[FLOW_LSB +: 3] = 3'(f);
            if (i == 5) d[47:0] = sent;
            if (i == 6) begin
                d[127:96] = seq;
                d[19:16]  = sh;
                d[8:0]    = sid;
            end
            drive_beat(typ, last ? inv : 4'd0, d, last, last ? valid : 1'b0,
                       last ? ts_tail : {$urandom, 16'(0)}, last ? crst : 1'b0);
        end
    endtask

    task automatic do_cnt_rst();
        cnt_rst = 1'b1;
        @(posedge clk);
        #1;
        cnt_rst = 1'b0;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (flow_cnt_o[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset flow_cnt_%0d: got %0d expected 0", i, flow_cnt_o[i]);
            end
        end
        checks++;
        if ({lost_o, seq_err_o, len_err_o} !== 96'd0) begin
            failures++;
            $display("FAIL reset err_cnts: got %0d/%0d/%0d expected 0", lost_o, seq_err_o, len_err_o);
        end
        checks++;
        if ({last_lat_o, max_lat_o} !== 96'd0) begin
            failures++;
            $display("FAIL reset latency: got %0d/%0d expected 0", last_lat_o, max_lat_o);
        end
        checks++;
        if ({slot_id_o, slot_shift_o} !== 13'd0) begin
            failures++;
            $display("FAIL reset slot: got %0d/%0d expected 0", slot_id_o, slot_shift_o);
        end
        checks++;
        if (dbg_state_o !== 3'd0) begin
            failures++;
            $display("FAIL reset state: got %0d expected 0", dbg_state_o);
        end
    endtask

    task automatic test_basic_and_seq();
        logic [47:0] exp_v, obs_v;
        logic [31:0] seqs [4];
        seqs[0] = 32'd1; seqs[1] = 32'd2; seqs[2] = 32'd5; seqs[3] = 32'd4;
        do_cnt_rst();
        for (int p = 0; p < 4; p++) begin
            send_pkt(2, 12'd160, 8, 4'd0, 1'b1, seqs[p], 48'd1000 + 48'(p * 7), 48'd1250 + 48'(p * 3),
                     9'(9'h055 + p), 4'(p + 3), 1'b0);
            for (int k = 0; k < 8; k++) begin
                exp_v = exp_q.pop_front();
                obs_v = observed(k, 2);
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL seq_pkt%0d %s: got %0d expected %0d", p, field_name(k), obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_short_and_len();
        logic [47:0] exp_v, obs_v;
        // 64-byte packet, then a length error, then the same bad packet discarded
        for (int p = 0; p < 3; p++) begin
            if (p == 0) send_pkt(5, 12'd96, 4, 4'd0, 1'b1, 32'd77, 48'd500, 48'd540, 9'h1FF, 4'hF, 1'b0);
            else        send_pkt(3, 12'd160, 8, 4'd4, (p == 1), 32'd1, 48'd10, 48'd90, 9'd3, 4'd1, 1'b0);
            for (int k = 0; k < 8; k++) begin
                exp_v = exp_q.pop_front();
                obs_v = observed(k, (p == 0) ? 5 : 3);
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL short_len%0d %s: got %0d expected %0d", p, field_name(k), obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_protocol_edges();
        logic [47:0]  exp_v, obs_v;
        logic [127:0] d;
        // head interrupting HDR beat 1 aborts the old packet
        d = '0;
        d[107:96] = 12'd160;
        drive_beat(2'b01, 4'd0, d, 1'b0, 1'b0, 48'd0, 1'b0);
        drive_beat(2'b11, 4'd0, '0, 1'b0, 1'b0, 48'd0, 1'b0);
        drive_beat(2'b11, 4'd0, '0, 1'b0, 1'b0, 48'd0, 1'b0);
        checks++;
        if (dbg_state_o !== 3'd2) begin
            failures++;
            $display("FAIL abort_state: got %0d expected 2", dbg_state_o);
        end
        m_len_err++;
        send_pkt(6, 12'd160, 8, 4'd0, 1'b1, m_exp_seq[6] + 32'd1, 48'd100, 48'd180, 9'd42, 4'd2, 1'b0);
        // stray tail and stray valid_wr in IDLE are ignored
        drive_beat(2'b10, 4'd0, '1, 1'b1, 1'b1, 48'd0, 1'b0);
        drive_beat(2'b11, 4'd0, '1, 1'b1, 1'b1, 48'd0, 1'b0);
        push_expected(6);
        // truncated packets: tail at MD2 and tail at HDR beat 1
        send_pkt(6, 12'd160, 0, 4'd0, 1'b1, 32'd0, 48'd0, 48'd0, 9'd0, 4'd0, 1'b0);
        send_pkt(6, 12'd160, 2, 4'd0, 1'b1, 32'd0, 48'd0, 48'd0, 9'd0, 4'd0, 1'b0);
        // exp_q now holds four snapshots; the DUT only shows the final one
        repeat (3) for (int k = 0; k < 8; k++) void'(exp_q.pop_front());
        for (int k = 0; k < 8; k++) begin
            exp_v = exp_q.pop_front();
            obs_v = observed(k, 6);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL edges %s: got %0d expected %0d", field_name(k), obs_v, exp_v);
            end
        end
        checks++;
        if (dbg_state_o !== 3'd0) begin
            failures++;
            $display("FAIL edges_state: got %0d expected 0", dbg_state_o);
        end
    endtask

    task automatic test_random();
        logic [47:0] exp_v, obs_v, sent;
        logic [11:0] len;
        logic [3:0]  inv;
        int          f, n;
        for (int p = 0; p < 16; p++) begin
            f    = $urandom_range(0, 7);
            n    = $urandom_range(5, 9);
            inv  = 4'($urandom_range(0, 15));
            len  = 12'(n * 16 + 32) - {8'd0, inv};
            if ($urandom_range(0, 4) == 0) len = len + 12'd16;
            sent = {$urandom, 16'($urandom)};
            send_pkt(f, len, n, inv, ($urandom_range(0, 5) != 0),
                     m_exp_seq[f] + 32'($urandom_range(0, 3)), sent, sent + 48'($urandom_range(1, 5000)),
                     9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)), 1'b0);
            for (int k = 0; k < 8; k++) begin
                exp_v = exp_q.pop_front();
                obs_v = observed(k, f);
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL rand%0d %s: got %0d expected %0d", p, field_name(k), obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_wrap_and_cnt_rst();
        logic [47:0] exp_v, obs_v;
        for (int p = 0; p < 2; p++) begin
            send_pkt(1, 12'd112, 5, 4'd0, 1'b1, m_exp_seq[1] + 32'd1, 48'hFFFF_FFFF_FFF6, 48'd20,
                     9'd7, 4'd9, (p == 1));
            for (int k = 0; k < 8; k++) begin
                exp_v = exp_q.pop_front();
                obs_v = observed(k, 1);
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL wrap_rst%0d %s: got %0d expected %0d", p, field_name(k), obs_v, exp_v);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (flow_cnt_o[i] !== m_flow_cnt[i]) begin
                failures++;
                $display("FAIL cnt_rst flow_cnt_%0d: got %0d expected %0d", i, flow_cnt_o[i], m_flow_cnt[i]);
            end
        end
        // expected_seq must have been cleared: seq 1 on flow 2 is in order again
        send_pkt(2, 12'd112, 5, 4'd0, 1'b1, 32'd1, 48'd0, 48'd5, 9'd1, 4'd1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            exp_v = exp_q.pop_front();
            obs_v = observed(k, 2);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL post_rst %s: got %0d expected %0d", field_name(k), obs_v, exp_v);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        cnt_rst = 1'b0;
        timestamp = '0;
        rxc_if.in_rxc_data = '0;
        rxc_if.in_rxc_data_wr = 1'b0;
        rxc_if.in_rxc_data_valid = 1'b0;
        rxc_if.in_rxc_data_valid_wr = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_and_seq();
        test_short_and_len();
        test_protocol_edges();
        test_random();
        test_wrap_and_cnt_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
